keypad_emitter: RTL
===================

Name: keypad_emitter

Overview:
- Transmit-side counterpart of the keypad row/column interface consumed by sysArray.
- Accepts 4-bit key codes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each code on rin/cin as a timed one-hot press, then releases both buses to all-zero for a gap.
- Used for on-chip self-test and for host-driven loading of the systolic array in place of a physical keypad.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of 2, from 2 to 16.
- PRESS_CYC, 2: cycles rin/cin are held at the key value; legal range 1..255.
- GAP_CYC, 2: cycles rin/cin are held at zero after each press; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_code  in  4  key to emit: [3:2] row index, [1:0] column index.
- key_valid  in  1  key_code is presented.
- key_ready  out  1  FIFO can accept; equals !full (combinational).
- abort  in  1  synchronous flush, one cycle wide.
- rin  out  4  one-hot row; 0 when released. Registered.
- cin  out  4  one-hot column; 0 when released. Registered.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; FIFO pointers and level are cleared; counter is cleared.
  - rin=0, cin=0, busy=0, level=0, key_ready=1.
- Push: a key is written when key_valid && key_ready at a clock edge.
  - key_ready is from full only. When the FIFO is full, a same-cycle pop does not admit a push.
- Decode of a popped code:
  - rin = 4'b0001 << code[3:2]
  - cin = 4'b0001 << code[1:0]
  - Exactly one bit is set on each bus during PRESS.
- FSM states: IDLE, PRESS, GAP. An 8-bit down-counter times PRESS and GAP.
- IDLE:
  - If the FIFO is non-empty: pop, load rin/cin, set counter=PRESS_CYC-1, go to PRESS.
  - Latency: a key pushed at edge N into an empty FIFO in IDLE appears on rin/cin after edge N+1.
- PRESS:
  - rin/cin hold the key value.
  - When counter=0: clear rin/cin to 0, set counter=GAP_CYC-1, go to GAP. Otherwise decrement the counter.
- GAP:
  - rin/cin=0.
  - When counter=0: if the FIFO is non-empty, pop and go directly to PRESS with no IDLE cycle; otherwise go to IDLE.
  - Otherwise decrement the counter.
- Steady-stream period: exactly PRESS_CYC+GAP_CYC cycles per key.
- Occupancy:
  - A pop and a push in the same cycle leave level unchanged.
  - Pointers wrap modulo DEPTH.
  - level=DEPTH means full; level=0 means empty.
- abort (sampled at the edge):
  - Empties the FIFO and forces rin=cin=0.
  - From PRESS, goes to GAP with counter=GAP_CYC-1 so the release is always observed. From GAP, restarts that gap count. From IDLE, stays in IDLE.
  - abort has priority over a same-cycle push: the pushed key is discarded.
- Invariant: rin and cin are either both zero or both one-hot. No other pattern is legal at any cycle.

Optional Feature:
- Macro: KEY_BOUNCE_EN.
- When defined, every PRESS is preceded by a 3-cycle bounce prefix:
  - Prefix pattern: key, 0, key. The steady PRESS_CYC hold follows.
  - Period becomes PRESS_CYC+GAP_CYC+3.
  - Added state: BOUNCE, with its own 2-bit counter.
  - abort during BOUNCE behaves as abort during PRESS.
- When undefined: no BOUNCE state, no extra logic, timing exactly as above.

Test Plan:
- Reset and single key: deassert rst, push code 4'b0001 at edge N.
  - rin=0001, cin=0010 after edge N+1 for 2 cycles.
  - Then rin=cin=0 for 2 cycles.
  - busy falls on the cycle IDLE is re-entered; level goes 1→0 at edge N+1.
- Back-to-back stream: push 4'b0110, 4'b0100, 4'b1000 on consecutive cycles.
  - Presses rin/cin = 0010/0100, 0010/0001, 0100/0001.
  - Each press starts exactly 4 cycles after the previous one; no IDLE cycle between them.
- Full FIFO: push 5 keys with DEPTH=4 while the first is pressing.
  - level reaches 4 and key_ready=0 while full.
  - The refused push leaves level and contents unchanged.
  - Emitted order matches push order.
- Abort mid-PRESS: abort on the 1st PRESS cycle with 3 keys queued.
  - Next cycle rin=cin=0, level=0.
  - 2 gap cycles, then IDLE; no further presses.
- Asynchronous reset mid-PRESS: drop rst between clock edges.
  - rin/cin/busy/level go to 0 immediately without waiting for an edge.
  - After release, a new push behaves as in the first scenario.
- KEY_BOUNCE_EN build: push 4'b0001.
  - rin/cin sequence: 0001/0010, 0/0, 0001/0010, then 0001/0010 held 2 cycles, then 0/0 for 2 cycles.

Source files
------------

// File: rtl/keypad_emitter_if.sv
`default_nettype none
// ============================================================================
// keypad_emitter_if : key-code valid/ready handshake into keypad_emitter
// Revision: 1.0 - initial release
// ============================================================================
interface keypad_emitter_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    modport master (output key_code, output key_valid, input key_ready);
    modport slave  (input key_code, input key_valid, output key_ready);
endinterface
`default_nettype wire

// File: rtl/keypad_emitter.sv
`default_nettype none
// ============================================================================
// keypad_emitter : buffers key codes and replays them as timed one-hot
//                  row/column presses. KEY_BOUNCE_EN adds a bounce prefix.
// Revision: 1.0 - initial release
// ============================================================================
module keypad_emitter #(
    parameter int DEPTH     = 4,
    parameter int PRESS_CYC = 2,
    parameter int GAP_CYC   = 2
) (
    input  wire                    clk,
    input  wire                    rst,
    keypad_emitter_if.slave        key_if,
    input  wire                    abort,
    output logic [3:0]             rin,
    output logic [3:0]             cin,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_FULL     = c_LW'(DEPTH);
    localparam logic [7:0]      c_PRESS_LD = 8'(PRESS_CYC - 1);
    localparam logic [7:0]      c_GAP_LD   = 8'(GAP_CYC - 1);

`ifdef KEY_BOUNCE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP, ST_BOUNCE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_t;
`endif

    logic [3:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_LW-1:0] r_level;
    state_t          r_state, w_state_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [3:0]      r_rin, r_cin, w_rin_nxt, w_cin_nxt;
    logic            w_push, w_pop, w_start, w_empty, w_full;
    logic [3:0]      w_head, w_head_rin, w_head_cin;
`ifdef KEY_BOUNCE_EN
    logic [1:0]      r_bcnt, w_bcnt_nxt;
    logic [3:0]      r_key_rin, r_key_cin;
`endif

    assign w_full      = (r_level == c_FULL);
    assign w_empty     = (r_level == '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_rin  = 4'b0001 << w_head[3:2];
    assign w_head_cin  = 4'b0001 << w_head[1:0];
    // abort wins over a same-cycle push
    assign w_push      = key_if.key_valid && !w_full && !abort;

    assign key_if.key_ready = !w_full;
    assign rin   = r_rin;
    assign cin   = r_cin;
    assign level = r_level;
    assign busy  = (r_state != ST_IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= key_if.key_code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rin   <= '0;
            r_cin   <= '0;
`ifdef KEY_BOUNCE_EN
            r_bcnt    <= '0;
            r_key_rin <= '0;
            r_key_cin <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rin   <= w_rin_nxt;
            r_cin   <= w_cin_nxt;
`ifdef KEY_BOUNCE_EN
            r_bcnt <= w_bcnt_nxt;
            if (w_pop) begin
                r_key_rin <= w_head_rin;
                r_key_cin <= w_head_cin;
            end
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rin_nxt   = r_rin;
        w_cin_nxt   = r_cin;
        w_pop       = 1'b0;
        w_start     = 1'b0;
`ifdef KEY_BOUNCE_EN
        w_bcnt_nxt  = r_bcnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_start = !w_empty;
            end
            ST_PRESS: begin
                if (r_cnt == 8'd0) begin
                    w_rin_nxt   = 4'd0;
                    w_cin_nxt   = 4'd0;
                    w_cnt_nxt   = c_GAP_LD;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == 8'd0) begin
                    w_start     = !w_empty;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
`ifdef KEY_BOUNCE_EN
            // prefix pattern: key, 0, key, then the steady hold
            ST_BOUNCE: begin
                if (r_bcnt == 2'd2) begin
                    w_cnt_nxt   = c_PRESS_LD;
                    w_state_nxt = ST_PRESS;
                end else begin
                    w_bcnt_nxt = r_bcnt + 2'd1;
                    w_rin_nxt  = (r_bcnt == 2'd0) ? 4'd0 : r_key_rin;
                    w_cin_nxt  = (r_bcnt == 2'd0) ? 4'd0 : r_key_cin;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_start) begin
            w_pop     = 1'b1;
            w_rin_nxt = w_head_rin;
            w_cin_nxt = w_head_cin;
`ifdef KEY_BOUNCE_EN
            w_bcnt_nxt  = 2'd0;
            w_state_nxt = ST_BOUNCE;
`else
            w_cnt_nxt   = c_PRESS_LD;
            w_state_nxt = ST_PRESS;
`endif
        end

        // any active press is cut to a full gap so the release is visible
        if (abort) begin
            w_pop     = 1'b0;
            w_rin_nxt = 4'd0;
            w_cin_nxt = 4'd0;
            if (r_state == ST_IDLE) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_GAP;
                w_cnt_nxt   = c_GAP_LD;
            end
        end
    end
endmodule
`default_nettype wire
